// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronises, debounces and edge-detects the four active-low
//            user keys of the clock/alarm system. Produces debounced levels
//            and one-cycle press pulses; the two increment keys auto-repeat
//            while held.
// Ports    : clk_clk          - system clock (single domain)
//            reset_reset      - synchronous active-high reset
//            *_key_n          - raw asynchronous keys, 0 = pressed
//            btn_level[3:0]   - debounced levels, 1 = pressed
//                               [3] set_mode [2] inc_hour [1] inc_min [0] confirm
//            *_pulse          - one-cycle press pulses (inc_* also auto-repeat)
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES      = 1_000_000,
    parameter int REPEAT_DELAY_CYCLES  = 25_000_000,
    parameter int REPEAT_PERIOD_CYCLES = 5_000_000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       set_mode_key_n,
    input  logic       inc_hour_key_n,
    input  logic       inc_min_key_n,
    input  logic       confirm_key_n,
    output logic [3:0] btn_level,
    output logic       set_mode_pulse,
    output logic       inc_hour_pulse,
    output logic       inc_min_pulse,
    output logic       confirm_pulse
);

    localparam int c_DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_HOLD_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int c_HOLD_W   = $clog2(c_HOLD_MAX + 1);

    // Terminal values are "one before" the cycle count: the count register
    // holds the number of cycles already elapsed, so the event fires on the
    // edge that would take it to the full count.
    localparam logic [c_DB_W-1:0]   c_DB_LAST     = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_DELAY_LAST  = c_HOLD_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_PERIOD_LAST = c_HOLD_W'(REPEAT_PERIOD_CYCLES - 1);

    logic [3:0] w_key_n;
    logic [3:0] w_level;
    logic [3:0] w_pulse;

    assign w_key_n = {set_mode_key_n, inc_hour_key_n, inc_min_key_n, confirm_key_n};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            logic [1:0]        r_sync;
            logic              w_sync;
            logic [c_DB_W-1:0] r_db_cnt;
            logic              r_level;
            logic              w_level_nxt;
            logic              w_accept;
            logic              w_press;

            // Inversion happens before the first flop so reset (0) means released.
            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    r_sync <= 2'b00;
                end else begin
                    r_sync <= {r_sync[0], ~w_key_n[gi]};
                end
            end

            assign w_sync = r_sync[1];

            always_comb begin
                w_level_nxt = r_level;
                w_accept    = 1'b0;
                if ((w_sync != r_level) && (r_db_cnt == c_DB_LAST)) begin
                    w_level_nxt = w_sync;
                    w_accept    = 1'b1;
                end
            end

            assign w_press = w_accept & w_sync;

            // Any cycle where sync agrees with the level restarts the count,
            // so a bounce must be followed by a full stable window.
            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    r_level  <= 1'b0;
                    r_db_cnt <= '0;
                end else begin
                    r_level <= w_level_nxt;
                    if ((w_sync == r_level) || w_accept) begin
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
            end

            assign w_level[gi] = r_level;

            if ((gi == 1) || (gi == 2)) begin : g_repeat
                typedef enum logic [1:0] {
                    S_IDLE   = 2'd0,
                    S_DELAY  = 2'd1,
                    S_REPEAT = 2'd2
                } state_t;

                state_t              r_state;
                logic [c_HOLD_W-1:0] r_hold;
                logic                r_pulse;

                // The FSM looks at the next level so that a repeat pulse can
                // never land in the first cycle the debounced level reads 0.
                always_ff @(posedge clk_clk) begin
                    if (reset_reset) begin
                        r_state <= S_IDLE;
                        r_hold  <= '0;
                        r_pulse <= 1'b0;
                    end else begin
                        r_pulse <= 1'b0;
                        case (r_state)
                            S_IDLE: begin
                                if (w_press) begin
                                    r_pulse <= 1'b1;
                                    r_hold  <= '0;
                                    r_state <= S_DELAY;
                                end
                            end
                            S_DELAY: begin
                                if (!w_level_nxt) begin
                                    r_hold  <= '0;
                                    r_state <= S_IDLE;
                                end else if (r_hold == c_DELAY_LAST) begin
                                    r_pulse <= 1'b1;
                                    r_hold  <= '0;
                                    r_state <= S_REPEAT;
                                end else begin
                                    r_hold <= r_hold + 1'b1;
                                end
                            end
                            S_REPEAT: begin
                                if (!w_level_nxt) begin
                                    r_hold  <= '0;
                                    r_state <= S_IDLE;
                                end else if (r_hold == c_PERIOD_LAST) begin
                                    r_pulse <= 1'b1;
                                    r_hold  <= '0;
                                end else begin
                                    r_hold <= r_hold + 1'b1;
                                end
                            end
                            default: begin
                                r_hold  <= '0;
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end

                assign w_pulse[gi] = r_pulse;
            end else begin : g_plain
                logic r_pulse;

                always_ff @(posedge clk_clk) begin
                    if (reset_reset) begin
                        r_pulse <= 1'b0;
                    end else begin
                        r_pulse <= w_press;
                    end
                end

                assign w_pulse[gi] = r_pulse;
            end
        end
    endgenerate

    assign btn_level      = w_level;
    assign set_mode_pulse = w_pulse[3];
    assign inc_hour_pulse = w_pulse[2];
    assign inc_min_pulse  = w_pulse[1];
    assign confirm_pulse  = w_pulse[0];

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Self-checking bench for button_conditioner. Compares every cycle
//            against a behavioural model built from press age arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_n;   // [3] set_mode [2] inc_hour [1] inc_min [0] confirm
    logic [3:0] btn_level;
    logic       set_mode_pulse, inc_hour_pulse, inc_min_pulse, confirm_pulse;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES      (D),
        .REPEAT_DELAY_CYCLES  (RD),
        .REPEAT_PERIOD_CYCLES (RP)
    ) dut (
        .clk_clk        (clk),
        .reset_reset    (rst),
        .set_mode_key_n (key_n[3]),
        .inc_hour_key_n (key_n[2]),
        .inc_min_key_n  (key_n[1]),
        .confirm_key_n  (key_n[0]),
        .btn_level      (btn_level),
        .set_mode_pulse (set_mode_pulse),
        .inc_hour_pulse (inc_hour_pulse),
        .inc_min_pulse  (inc_min_pulse),
        .confirm_pulse  (confirm_pulse)
    );

    // Model: two-deep delay line, a run length of disagreeing cycles, and the
    // age of the current accepted press (-1 when not held).
    bit m_s1[4], m_s2[4], m_lvl[4], m_pulse[4];
    int m_run[4], m_age[4];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic model_edge();
        for (int c = 0; c < 4; c++) begin
            if (rst) begin
                m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_pulse[c] = 0;
                m_run[c] = 0; m_age[c] = -1;
            end else begin
                bit changed;
                changed    = 0;
                m_pulse[c] = 0;
                if (m_s2[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_lvl[c] = m_s2[c];
                        m_run[c] = 0;
                        changed  = 1;
                        if (m_lvl[c]) begin
                            m_pulse[c] = 1;
                            m_age[c]   = 0;
                        end else begin
                            m_age[c] = -1;
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (!changed && m_lvl[c] && m_age[c] >= 0) begin
                    m_age[c]++;
                    if ((c == 1 || c == 2) && m_age[c] >= RD && ((m_age[c] - RD) % RP) == 0)
                        m_pulse[c] = 1;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = ~key_n[c];
            end
        end
    endtask

    task automatic step();
        logic [7:0] obs, exp_v;
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        obs   = {btn_level, set_mode_pulse, inc_hour_pulse, inc_min_pulse, confirm_pulse};
        exp_v = {m_lvl[3], m_lvl[2], m_lvl[1], m_lvl[0],
                 m_pulse[3], m_pulse[2], m_pulse[1], m_pulse[0]};
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL cyc%0d level_pulses observed=%b expected=%b", cyc, obs, exp_v);
        end
    endtask

    initial begin
        int cd[4];
        int rst_cd;

        // Reset with keys released; the first step checks the reset state.
        rst   = 1'b1;
        key_n = 4'hF;
        repeat (3) step();
        rst = 1'b0;

        // All four pressed together, held long enough for several repeats.
        key_n = 4'h0;
        repeat (80) step();
        key_n = 4'hF;
        repeat (20) step();

        // Key held through a reset pulse, then treated as a fresh press.
        key_n = 4'b1101;
        repeat (30) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (40) step();
        key_n = 4'hF;
        repeat (15) step();

        // Random bouncing, glitches, long holds and occasional resets.
        for (int c = 0; c < 4; c++) cd[c] = $urandom_range(1, 40);
        rst_cd = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 4; c++) begin
                cd[c]--;
                if (cd[c] <= 0) begin
                    key_n[c] = ~key_n[c];
                    cd[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                        : $urandom_range(5, 80);
                end
            end
            if (rst_cd > 0) begin
                rst_cd--;
                rst = (rst_cd > 0);
            end else if ($urandom_range(0, 499) == 0) begin
                rst    = 1'b1;
                rst_cd = $urandom_range(2, 4);
            end
            step();
        end
        rst = 1'b0;
        key_n = 4'hF;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
